array_sort_check_datapath: RTL and testbench
============================================

# array_sort_check_datapath

Datapath partner of the array sort-check control FSM: holds the array base and length, walks an element index, issues two combinational word-read addresses per step and compares adjacent elements. It consumes the FSM's load_input / load_index / select_index strobes and produces the inversion_found / end_of_array / zero_length_array status the FSM branches on. It also keeps a saturating comparison counter for debug and performance visibility.

## Interface
- DATA_WIDTH, 32: element width in bits; elements occupy one 4-byte word each.
- SIGNED_CMP, 1: 1 = signed element compare, 0 = unsigned.
- CNT_WIDTH, 16: width of compare_count.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; all registers clear while low.
- array_base  in  32  byte address of element 0; sampled on load_input.
- array_length  in  32  element count; sampled on load_input.
- load_input  in  1  capture array_base / array_length; clear compare_count.
- load_index  in  1  index register write enable.
- select_index  in  1  index source: 0 = zero, 1 = index+1.
- rd_addr0  out  32  byte address of element[index].
- rd_addr1  out  32  byte address of element[index+1].
- rd_data0  in  DATA_WIDTH  combinational read data for rd_addr0.
- rd_data1  in  DATA_WIDTH  combinational read data for rd_addr1.
- inversion_found  out  1  element[index] > element[index+1], valid compare only.
- end_of_array  out  1  index is the last element (no further pair).
- zero_length_array  out  1  stored length is 0.
- compare_count  out  CNT_WIDTH  pair advances since last load_input, saturating.

## Operation
- Registers: base_r[31:0], length_r[31:0], index_r[31:0], count_r[CNT_WIDTH-1:0].
- load_input=1: base_r<=array_base, length_r<=array_length, count_r<=0.
- load_index=1: index_r <= select_index ? index_r+1 : 0; load_index=0 holds index_r.
- count_r increments when load_index & select_index & ~load_input and count_r != all-ones; saturates at all-ones; load_input wins on simultaneous assertion.
- rd_addr0 = base_r + (index_r << 2); rd_addr1 = rd_addr0 + 4; both modulo 2^32 (wrap silently).
- zero_length_array = (length_r == 0).
- end_of_array = ~zero_length_array & (index_r + 1 >= length_r), compared in 33 bits so index_r = 0xFFFFFFFF does not wrap to false.
- inversion_found = ~zero_length_array & ~end_of_array & (rd_data0 > rd_data1), signedness per SIGNED_CMP; equal elements are not an inversion.
- All three flags are mutually exclusive by construction; flags and addresses are purely combinational from registers and read data.
- Datapath never stops on its own: FSM owns sequencing; index may exceed length if FSM keeps advancing, flags stay consistent with the formula above.

## Timing
- Reset (reset low, asynchronous): base_r, length_r, index_r, count_r = 0; hence rd_addr0=0, rd_addr1=4, zero_length_array=1, end_of_array=0, inversion_found=0, compare_count=0.
- Register updates take effect on the rising edge where the strobe is high; flags reflect new values in the following cycle (same cycle as FSM's Check state after Start/GoOn).
- Zero-cycle combinational path rd_data* -> inversion_found; memory read must be combinational.
- Reset asserted mid-walk clears everything immediately; deassertion is synchronised externally; first edge after deassertion behaves as a normal edge.
- load_input and load_index in the same cycle (FSM Start state): both take effect on one edge.

## Structure
- Shared package: WORD_BYTES=4, ADDR_WIDTH=32, index width constant, default DATA_WIDTH.
- One sub-module: sort_check_compare (parameterised DATA_WIDTH/SIGNED_CMP greater-than comparator), instantiated once.
- Registers use async active-low reset flops; no other hierarchy.

## Test plan
- Reset low mid-operation with index_r=5 -> all outputs at reset values within the same cycle, zero_length_array=1.
- Load base=0x1000, length=4, array {1,2,2,7}, walk index 0..3 -> rd_addr0 0x1000/0x1004/0x1008/0x100C, inversion_found always 0, end_of_array=1 only at index 3, compare_count=3.
- Load length=3, array {5,9,4} signed -> inversion_found=1 at index 1 only; unsigned array {0xFFFFFFFF,1}: SIGNED_CMP=1 -> 0, SIGNED_CMP=0 -> 1.
- Load length=0 -> zero_length_array=1, end_of_array=0, inversion_found=0 regardless of rd_data; length=1 -> end_of_array=1 at index 0.
- base=0xFFFFFFFC, index 0 -> rd_addr0=0xFFFFFFFC, rd_addr1=0x00000000 (wrap).
- CNT_WIDTH=4, advance 20 times -> compare_count saturates at 15; load_input with simultaneous advance -> compare_count=0.

Source files
------------

// File: rtl/array_sort_check_datapath_pkg.sv
// Shared constants for the array sort-check datapath and its comparator.
package array_sort_check_datapath_pkg;
    localparam int unsigned WORD_BYTES         = 4;
    localparam int unsigned WORD_SHIFT         = 2;
    localparam int unsigned ADDR_WIDTH         = 32;
    localparam int unsigned INDEX_WIDTH        = 32;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
endpackage

// File: rtl/array_sort_check_datapath_compare.sv
// Greater-than comparator for adjacent array elements, signedness set at elaboration.
module sort_check_compare #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          SIGNED_CMP = 1'b1
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  gt_o
);
    always_comb begin
        if (SIGNED_CMP) begin
            gt_o = $signed(a_i) > $signed(b_i);
        end else begin
            gt_o = a_i > b_i;
        end
    end
endmodule

// File: rtl/array_sort_check_datapath.sv
// Sort-check datapath: base/length/index registers, pair read addresses,
// adjacent-element compare and a saturating pair-advance counter.
module array_sort_check_datapath
    import array_sort_check_datapath_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter bit          SIGNED_CMP = 1'b1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] array_base,
    input  logic [31:0]           array_length,
    input  logic                  load_input,
    input  logic                  load_index,
    input  logic                  select_index,
    output logic [ADDR_WIDTH-1:0] rd_addr0,
    output logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [DATA_WIDTH-1:0] rd_data0,
    input  logic [DATA_WIDTH-1:0] rd_data1,
    output logic                  inversion_found,
    output logic                  end_of_array,
    output logic                  zero_length_array,
    output logic [CNT_WIDTH-1:0]  compare_count
);
    logic [ADDR_WIDTH-1:0]  base_q,   base_d;
    logic [31:0]            length_q, length_d;
    logic [INDEX_WIDTH-1:0] index_q,  index_d;
    logic [CNT_WIDTH-1:0]   count_q,  count_d;
    logic                   advance;
    logic [INDEX_WIDTH:0]   index_plus1;
    logic                   elem_gt;

    assign advance = load_index & select_index;

    always_comb begin
        base_d   = base_q;
        length_d = length_q;
        index_d  = index_q;
        count_d  = count_q;
        if (load_input) begin
            base_d   = array_base;
            length_d = array_length;
        end
        if (load_index) begin
            index_d = select_index ? index_q + INDEX_WIDTH'(1) : '0;
        end
        // A fresh load always restarts the count, even if the FSM also advances.
        if (load_input) begin
            count_d = '0;
        end else if (advance && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            base_q   <= '0;
            length_q <= '0;
            index_q  <= '0;
            count_q  <= '0;
        end else begin
            base_q   <= base_d;
            length_q <= length_d;
            index_q  <= index_d;
            count_q  <= count_d;
        end
    end

    assign rd_addr0 = base_q + (ADDR_WIDTH'(index_q) << WORD_SHIFT);
    assign rd_addr1 = rd_addr0 + ADDR_WIDTH'(WORD_BYTES);

    // Extra bit keeps index 0xFFFFFFFF from wrapping the +1 back to zero.
    assign index_plus1 = {1'b0, index_q} + (INDEX_WIDTH+1)'(1);

    sort_check_compare #(
        .DATA_WIDTH(DATA_WIDTH),
        .SIGNED_CMP(SIGNED_CMP)
    ) u_compare (
        .a_i (rd_data0),
        .b_i (rd_data1),
        .gt_o(elem_gt)
    );

    assign zero_length_array = (length_q == 32'd0);
    assign end_of_array      = ~zero_length_array & (index_plus1 >= {1'b0, length_q});
    assign inversion_found   = ~zero_length_array & ~end_of_array & elem_gt;
    assign compare_count     = count_q;
endmodule

// File: tb/tb_array_sort_check_datapath.sv
// Directed bench: a signed/16-bit-counter instance and an unsigned/4-bit-counter
// instance share all inputs; expectations are hand-computed constants.
module tb_array_sort_check_datapath;
    logic        clock;
    logic        reset;
    logic [31:0] array_base;
    logic [31:0] array_length;
    logic        load_input;
    logic        load_index;
    logic        select_index;
    logic [31:0] rd_data0;
    logic [31:0] rd_data1;

    logic [31:0] s_addr0, s_addr1, u_addr0, u_addr1;
    logic        s_inv, s_end, s_zero, u_inv, u_end, u_zero;
    logic [15:0] s_count;
    logic [3:0]  u_count;

    int checks = 0;
    int errors = 0;

    array_sort_check_datapath #(.DATA_WIDTH(32), .SIGNED_CMP(1'b1), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset),
        .array_base(array_base), .array_length(array_length),
        .load_input(load_input), .load_index(load_index), .select_index(select_index),
        .rd_addr0(s_addr0), .rd_addr1(s_addr1),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .inversion_found(s_inv), .end_of_array(s_end), .zero_length_array(s_zero),
        .compare_count(s_count)
    );

    array_sort_check_datapath #(.DATA_WIDTH(32), .SIGNED_CMP(1'b0), .CNT_WIDTH(4)) dut_u (
        .clock(clock), .reset(reset),
        .array_base(array_base), .array_length(array_length),
        .load_input(load_input), .load_index(load_index), .select_index(select_index),
        .rd_addr0(u_addr0), .rd_addr1(u_addr1),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .inversion_found(u_inv), .end_of_array(u_end), .zero_length_array(u_zero),
        .compare_count(u_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [31:0] base, input logic [31:0] len);
        array_base   = base;
        array_length = len;
        load_input   = 1'b1;
        load_index   = 1'b1;
        select_index = 1'b0;
        cycle();
        load_input   = 1'b0;
        load_index   = 1'b0;
    endtask

    task automatic advance();
        load_index   = 1'b1;
        select_index = 1'b1;
        cycle();
        load_index   = 1'b0;
        select_index = 1'b0;
    endtask

    task automatic set_pair(input logic [31:0] a, input logic [31:0] b);
        rd_data0 = a;
        rd_data1 = b;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr0"}, s_addr0, 32'h0);
        check({tag, "_addr1"}, s_addr1, 32'h4);
        check({tag, "_zero"},  s_zero,  1'b1);
        check({tag, "_end"},   s_end,   1'b0);
        check({tag, "_inv"},   s_inv,   1'b0);
        check({tag, "_count"}, s_count, 16'd0);
        check({tag, "_ucount"}, u_count, 4'd0);
    endtask

    initial begin
        logic [31:0] arr4 [4];
        logic [31:0] arr3 [3];
        arr4 = '{32'd1, 32'd2, 32'd2, 32'd7};
        arr3 = '{32'd5, 32'd9, 32'd4};

        reset = 1'b0;
        array_base = '0; array_length = '0;
        load_input = 1'b0; load_index = 1'b0; select_index = 1'b0;
        rd_data0 = 32'd5; rd_data1 = 32'd1;
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("por");
        @(negedge clock);
        reset = 1'b1;

        // Reset asserted mid-walk at index 5
        do_load(32'h2000, 32'd8);
        repeat (5) advance();
        check("mid_addr0", s_addr0, 32'h2014);
        check("mid_count", s_count, 16'd5);
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clock);
        reset = 1'b1;

        // Sorted array with duplicates
        do_load(32'h1000, 32'd4);
        for (int i = 0; i < 4; i++) begin
            set_pair(arr4[i], (i < 3) ? arr4[i+1] : 32'd0);
            check($sformatf("walk_addr0_%0d", i), s_addr0, 32'h1000 + 32'(4 * i));
            check($sformatf("walk_addr1_%0d", i), s_addr1, 32'h1004 + 32'(4 * i));
            check($sformatf("walk_inv_%0d", i),   s_inv,   1'b0);
            check($sformatf("walk_end_%0d", i),   s_end,   (i == 3));
            if (i < 3) advance();
        end
        check("walk_count", s_count, 16'd3);

        // Signed inversion in the middle pair
        do_load(32'h3000, 32'd3);
        for (int i = 0; i < 3; i++) begin
            set_pair(arr3[i], (i < 2) ? arr3[i+1] : 32'd0);
            check($sformatf("inv_flag_%0d", i), s_inv, (i == 1));
            check($sformatf("inv_end_%0d", i),  s_end, (i == 2));
            if (i < 2) advance();
        end

        // 0xFFFFFFFF vs 1: -1 < 1 signed, huge > 1 unsigned
        do_load(32'h4000, 32'd2);
        set_pair(32'hFFFF_FFFF, 32'd1);
        check("sign_inv_signed",   s_inv, 1'b0);
        check("sign_inv_unsigned", u_inv, 1'b1);

        // Zero and one-element arrays
        do_load(32'h5000, 32'd0);
        set_pair(32'd9, 32'd1);
        check("len0_zero", s_zero, 1'b1);
        check("len0_end",  s_end,  1'b0);
        check("len0_inv",  s_inv,  1'b0);
        check("len0_uinv", u_inv,  1'b0);
        do_load(32'h5000, 32'd1);
        check("len1_zero", s_zero, 1'b0);
        check("len1_end",  s_end,  1'b1);
        check("len1_inv",  s_inv,  1'b0);

        // Address wrap at top of address space
        do_load(32'hFFFF_FFFC, 32'd4);
        check("wrap_addr0", s_addr0, 32'hFFFF_FFFC);
        check("wrap_addr1", s_addr1, 32'h0000_0000);

        // Counter saturation and index running past the length
        do_load(32'h0, 32'd4);
        repeat (20) advance();
        set_pair(32'd9, 32'd1);
        check("sat_ucount", u_count, 4'd15);
        check("sat_count",  s_count, 16'd20);
        check("past_end",   s_end,   1'b1);
        check("past_inv",   s_inv,   1'b0);
        check("past_addr0", s_addr0, 32'h50);

        // load_input wins over a simultaneous advance
        array_base = 32'h6000; array_length = 32'd4;
        load_input = 1'b1; load_index = 1'b1; select_index = 1'b1;
        cycle();
        load_input = 1'b0; load_index = 1'b0; select_index = 1'b0;
        check("clr_count",  s_count, 16'd0);
        check("clr_ucount", u_count, 4'd0);
        check("clr_addr0",  s_addr0, 32'h6054);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
